// File: rtl/tdc_pkg.sv
// Shared types and default sizing for the delay-line TDC measurement controller.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    RUN,
    SAMPLE,
    ENCODE,
    DONE
  } tdc_state_e;

  localparam int unsigned TDC_NTAPS    = 32;
  localparam int unsigned TDC_FINE_W   = 6;
  localparam int unsigned TDC_COARSE_W = 10;
  localparam int unsigned TDC_CLR_CYC  = 2;
  localparam int unsigned TDC_AVG_LOG2 = 2;

endpackage

// File: rtl/tdc_therm_enc.sv
// Thermometer-to-binary encoder: popcount of the sampled taps, so isolated bubbles
// in the code shift the result by one tap instead of corrupting it.
module tdc_therm_enc
  import tdc_pkg::*;
#(
  parameter int unsigned NTAPS  = TDC_NTAPS,
  parameter int unsigned FINE_W = TDC_FINE_W
) (
  input  logic [NTAPS-1:0]  therm_i,
  output logic [FINE_W-1:0] fine_o
);

  always_comb begin
    fine_o = '0;
    for (int i = 0; i < NTAPS; i++) begin
      fine_o = fine_o + FINE_W'(therm_i[i]);
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Delay-line TDC sequencer: clear, arm, coarse count, sample/encode, valid/ready result.
// Define TDC_AVG_EN to average 2^AVG_LOG2 shots per result (adds the AVG_LOG2 parameter).
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned NTAPS    = TDC_NTAPS,
  parameter int unsigned FINE_W   = TDC_FINE_W,
  parameter int unsigned COARSE_W = TDC_COARSE_W,
  parameter int unsigned CLR_CYC  = TDC_CLR_CYC
`ifdef TDC_AVG_EN
  ,
  parameter int unsigned AVG_LOG2 = TDC_AVG_LOG2
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       meas_req,
  input  logic                       meas_abort,
  input  logic [COARSE_W-1:0]        timeout_cyc,
  input  logic                       start_evt,
  input  logic                       stop_evt,
  input  logic [NTAPS-1:0]           therm,
  output logic                       tdc_clear,
  output logic                       tdc_arm,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [COARSE_W+FINE_W-1:0] res_data,
  output logic                       res_timeout
);

  localparam int unsigned RES_W = COARSE_W + FINE_W;

  tdc_state_e           state_q, state_d;
  logic [COARSE_W-1:0]  cnt_q, cnt_d;
  logic                 start_prev_q, stop_prev_q;
  logic [NTAPS-1:0]     therm_q, therm_d;
  logic [RES_W-1:0]     res_data_q, res_data_d;
  logic                 res_to_q, res_to_d;
  logic [FINE_W-1:0]    fine_enc;
  logic [COARSE_W-1:0]  limit;
  logic                 start_rise, stop_rise;

  assign start_rise = start_evt & ~start_prev_q;
  assign stop_rise  = stop_evt & ~stop_prev_q;
  assign limit      = (timeout_cyc == '0) ? '1 : timeout_cyc;

  tdc_therm_enc #(
    .NTAPS (NTAPS),
    .FINE_W(FINE_W)
  ) u_enc (
    .therm_i(therm_q),
    .fine_o (fine_enc)
  );

`ifdef TDC_AVG_EN
  localparam int unsigned ACC_W  = RES_W + AVG_LOG2;
  localparam int unsigned SHOT_W = AVG_LOG2 + 1;
  localparam logic [SHOT_W-1:0] SHOT_LAST = SHOT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SHOT_W-1:0]   shot_q, shot_d;
  logic [ACC_W-1:0]    lin, acc_sum, avg;
  logic [COARSE_W-1:0] avg_coarse;
  logic [FINE_W-1:0]   avg_fine;

  // Shots are summed as linear tap counts so fine carries into coarse correctly.
  assign lin        = ACC_W'(cnt_q) * ACC_W'(NTAPS) + ACC_W'(fine_enc);
  assign acc_sum    = acc_q + lin;
  assign avg        = acc_sum >> AVG_LOG2;
  assign avg_coarse = COARSE_W'(avg / ACC_W'(NTAPS));
  assign avg_fine   = FINE_W'(avg % ACC_W'(NTAPS));
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    therm_d    = therm_q;
    res_data_d = res_data_q;
    res_to_d   = res_to_q;
`ifdef TDC_AVG_EN
    acc_d      = acc_q;
    shot_d     = shot_q;
`endif
    tdc_clear  = 1'b0;
    tdc_arm    = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (meas_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
`ifdef TDC_AVG_EN
          acc_d   = '0;
          shot_d  = '0;
`endif
        end
      end
      CLEAR: begin
        tdc_clear = 1'b1;
        if (meas_abort) begin
          state_d = IDLE;
        end else if (cnt_q == COARSE_W'(CLR_CYC - 1)) begin
          state_d = ARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + COARSE_W'(1);
        end
      end
      ARM: begin
        tdc_arm = 1'b1;
        if (meas_abort) begin
          state_d = IDLE;
        end else if (start_rise && stop_rise) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else if (start_rise) begin
          // Coarse is the number of edges from start to stop, so the start edge counts as one.
          state_d = RUN;
          cnt_d   = COARSE_W'(1);
        end else if (cnt_q == limit) begin
          state_d    = DONE;
          res_data_d = {{COARSE_W{1'b1}}, {FINE_W{1'b0}}};
          res_to_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + COARSE_W'(1);
        end
      end
      RUN: begin
        tdc_arm = 1'b1;
        if (meas_abort) begin
          state_d = IDLE;
        end else if (stop_rise) begin
          state_d = SAMPLE;
        end else if (cnt_q == limit) begin
          state_d    = DONE;
          res_data_d = {{COARSE_W{1'b1}}, {FINE_W{1'b0}}};
          res_to_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + COARSE_W'(1);
        end
      end
      SAMPLE: begin
        if (meas_abort) begin
          state_d = IDLE;
        end else begin
          therm_d = therm;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        if (meas_abort) begin
          state_d = IDLE;
        end else begin
`ifdef TDC_AVG_EN
          if (shot_q == SHOT_LAST) begin
            state_d    = DONE;
            res_data_d = {avg_coarse, avg_fine};
            res_to_d   = 1'b0;
          end else begin
            acc_d   = acc_sum;
            shot_d  = shot_q + SHOT_W'(1);
            cnt_d   = '0;
            state_d = CLEAR;
          end
`else
          state_d    = DONE;
          res_data_d = {cnt_q, fine_enc};
          res_to_d   = 1'b0;
`endif
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d    = IDLE;
          res_data_d = '0;
          res_to_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      res_data_q   <= '0;
      res_to_q     <= 1'b0;
`ifdef TDC_AVG_EN
      acc_q        <= '0;
      shot_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_evt;
      stop_prev_q  <= stop_evt;
      res_data_q   <= res_data_d;
      res_to_q     <= res_to_d;
`ifdef TDC_AVG_EN
      acc_q        <= acc_d;
      shot_q       <= shot_d;
`endif
    end
    therm_q <= therm_d;
  end

  assign busy        = (state_q != IDLE);
  assign res_data    = res_data_q;
  assign res_timeout = res_to_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl (default single-shot build).
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        meas_req;
  logic        meas_abort;
  logic [9:0]  timeout_cyc;
  logic        start_evt;
  logic        stop_evt;
  logic [31:0] therm;
  logic        tdc_clear;
  logic        tdc_arm;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdc_meas_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .meas_req   (meas_req),
    .meas_abort (meas_abort),
    .timeout_cyc(timeout_cyc),
    .start_evt  (start_evt),
    .stop_evt   (stop_evt),
    .therm      (therm),
    .tdc_clear  (tdc_clear),
    .tdc_arm    (tdc_arm),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_timeout(res_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: one request cycle, two CLEAR cycles, then sitting in ARM.
  task automatic go_arm();
    meas_req = 1'b1;
    step();
    meas_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; meas_req = 1'b0; meas_abort = 1'b0; timeout_cyc = '0;
    start_evt = 1'b0; stop_evt = 1'b0; therm = '0; res_ready = 1'b0;
    step(); step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (tdc_clear !== 1'b0) begin fails++; $display("FAIL reset_clear: got %b want 0", tdc_clear); end
    tests++; if (tdc_arm !== 1'b0) begin fails++; $display("FAIL reset_arm: got %b want 0", tdc_arm); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    tests++; if (res_data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h want 0000", res_data); end
    tests++; if (res_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", res_timeout); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    meas_req = 1'b1;
    step();
    meas_req = 1'b0;
    tests++; if ({busy, tdc_clear, tdc_arm} !== 3'b110) begin fails++; $display("FAIL basic_clear1: got %b want 110", {busy, tdc_clear, tdc_arm}); end
    step();
    tests++; if (tdc_clear !== 1'b1) begin fails++; $display("FAIL basic_clear2: got %b want 1", tdc_clear); end
    step();
    tests++; if ({tdc_clear, tdc_arm} !== 2'b01) begin fails++; $display("FAIL basic_arm: got %b want 01", {tdc_clear, tdc_arm}); end
    start_evt = 1'b1;
    repeat (5) step();
    stop_evt = 1'b1; therm = 32'h0000_00FF;
    step();
    tests++; if ({tdc_arm, res_valid} !== 2'b00) begin fails++; $display("FAIL basic_sample: got %b want 00", {tdc_arm, res_valid}); end
    step();
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL basic_encode_valid: got %b want 0", res_valid); end
    step();
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: got %b want 1", res_valid); end
    tests++; if (res_data !== 16'h0148) begin fails++; $display("FAIL basic_data: got %h want 0148", res_data); end
    tests++; if (res_timeout !== 1'b0) begin fails++; $display("FAIL basic_timeout: got %b want 0", res_timeout); end
    start_evt = 1'b0; stop_evt = 1'b0; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    tests++; if ({busy, res_valid} !== 2'b00) begin fails++; $display("FAIL basic_idle: got %b want 00", {busy, res_valid}); end
  endtask

  task automatic test_same_cycle();
    go_arm();
    start_evt = 1'b1; stop_evt = 1'b1; therm = '0;
    step();
    tests++; if ({busy, tdc_arm} !== 2'b10) begin fails++; $display("FAIL same_sample: got %b want 10", {busy, tdc_arm}); end
    start_evt = 1'b0; stop_evt = 1'b0;
    step(); step();
    tests++; if ({res_valid, res_timeout, res_data} !== {2'b10, 16'h0000}) begin
      fails++; $display("FAIL same_result: got v%b t%b %h want v1 t0 0000", res_valid, res_timeout, res_data);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_timeout_hold();
    timeout_cyc = 10'd20;
    go_arm();
    start_evt = 1'b1;
    repeat (20) step();
    tests++; if ({tdc_arm, res_valid} !== 2'b10) begin fails++; $display("FAIL tmo_running: got %b want 10", {tdc_arm, res_valid}); end
    step();
    tests++; if ({res_valid, res_timeout, tdc_arm} !== 3'b110) begin
      fails++; $display("FAIL tmo_flags: got %b want 110", {res_valid, res_timeout, tdc_arm});
    end
    tests++; if (res_data !== 16'hFFC0) begin fails++; $display("FAIL tmo_data: got %h want ffc0", res_data); end
    start_evt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++; if ({res_valid, res_timeout, res_data} !== {2'b11, 16'hFFC0}) begin
        fails++; $display("FAIL hold_stable[%0d]: got v%b t%b %h want v1 t1 ffc0", i, res_valid, res_timeout, res_data);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    tests++; if ({busy, res_valid} !== 2'b00) begin fails++; $display("FAIL hold_release: got %b want 00", {busy, res_valid}); end
    timeout_cyc = '0;
  endtask

  task automatic test_arm_timeout();
    int waited;
    timeout_cyc = 10'd3;
    go_arm();
    waited = 0;
    while (res_valid !== 1'b1 && waited < 12) begin
      step();
      waited++;
    end
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL arm_tmo_valid: got %b want 1 within 12 cycles", res_valid); end
    tests++; if ({res_timeout, res_data} !== {1'b1, 16'hFFC0}) begin
      fails++; $display("FAIL arm_tmo_data: got t%b %h want t1 ffc0", res_timeout, res_data);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    timeout_cyc = '0;
  endtask

  task automatic test_abort_reset();
    int seen;
    go_arm();
    start_evt = 1'b1;
    step(); step();
    tests++; if (tdc_arm !== 1'b1) begin fails++; $display("FAIL abort_run_arm: got %b want 1", tdc_arm); end
    meas_abort = 1'b1;
    step();
    meas_abort = 1'b0; start_evt = 1'b0;
    tests++; if ({busy, tdc_arm, tdc_clear} !== 3'b000) begin fails++; $display("FAIL abort_idle: got %b want 000", {busy, tdc_arm, tdc_clear}); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (res_valid === 1'b1) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
    go_arm();
    start_evt = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    tests++; if ({busy, tdc_arm, tdc_clear, res_valid, res_timeout, res_data} !== 21'd0) begin
      fails++; $display("FAIL rst_mid_run: got b%b a%b c%b v%b t%b %h want all 0", busy, tdc_arm, tdc_clear, res_valid, res_timeout, res_data);
    end
    rst = 1'b0; start_evt = 1'b0;
    step();
  endtask

  task automatic test_stop_ignored();
    go_arm();
    stop_evt = 1'b1;
    step(); step();
    tests++; if ({tdc_arm, busy, res_valid} !== 3'b110) begin fails++; $display("FAIL stop_in_arm: got %b want 110", {tdc_arm, busy, res_valid}); end
    stop_evt = 1'b0; start_evt = 1'b1;
    repeat (3) step();
    stop_evt = 1'b1; therm = 32'h0001_F0F7;
    repeat (3) step();
    tests++; if ({res_valid, res_data} !== {1'b1, 16'h00CC}) begin
      fails++; $display("FAIL bubble_result: got v%b %h want v1 00cc", res_valid, res_data);
    end
    start_evt = 1'b0; stop_evt = 1'b0; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    meas_req = 1'b1;
    step(); step(); step();
    start_evt = 1'b1; stop_evt = 1'b1; therm = '1;
    step();
    start_evt = 1'b0; stop_evt = 1'b0;
    step(); step();
    tests++; if ({res_valid, res_data} !== {1'b1, 16'h0020}) begin
      fails++; $display("FAIL b2b_full_scale: got v%b %h want v1 0020", res_valid, res_data);
    end
    meas_abort = 1'b1;
    step();
    meas_abort = 1'b0;
    tests++; if ({busy, res_valid, res_data} !== {2'b11, 16'h0020}) begin
      fails++; $display("FAIL done_ignores_abort: got b%b v%b %h want b1 v1 0020", busy, res_valid, res_data);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    tests++; if ({busy, res_valid} !== 2'b00) begin fails++; $display("FAIL b2b_idle: got %b want 00", {busy, res_valid}); end
    step();
    tests++; if ({busy, tdc_clear} !== 2'b11) begin fails++; $display("FAIL b2b_retrigger: got %b want 11", {busy, tdc_clear}); end
    meas_req = 1'b0; meas_abort = 1'b1;
    step();
    meas_abort = 1'b0;
    tests++; if ({busy, tdc_clear} !== 2'b00) begin fails++; $display("FAIL abort_in_clear: got %b want 00", {busy, tdc_clear}); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_timeout_hold();
    test_arm_timeout();
    test_abort_reset();
    test_stop_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
